// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core constants for register-file write-back: data width,
// register-index width and the hard-wired zero register.
package regfile_wb_arbiter_pkg;
  localparam int CORE_XLEN = 32;
  localparam int REG_AW    = 5;

  typedef logic [REG_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_X0 = '0;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins; under contention
// the pointer picks the winner (0 = requester 0, 1 = requester 1).
module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  output logic g0,
  output logic g1
);
  assign g0 = v0 & (~v1 | ~ptr);
  assign g1 = v1 & (~v0 |  ptr);
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU write-back requests onto the single register-file
// write port, one per cycle, with round-robin fairness and a stall counter.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int XLEN  = CORE_XLEN,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  input  reg_idx_t         req0_rd,
  input  logic [XLEN-1:0]  req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  reg_idx_t         req1_rd,
  input  logic [XLEN-1:0]  req1_data,
  output logic             req1_ready,
  output logic             regwrite,
  output reg_idx_t         write_reg,
  output logic [XLEN-1:0]  write_data,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic            rr_ptr;
  logic            g0, g1;
  logic            fire0, fire1, xfer, contend;
  reg_idx_t        sel_rd;
  logic [XLEN-1:0] sel_data;

  rr_arb2 u_arb (
    .v0  (req0_valid),
    .v1  (req1_valid),
    .ptr (rr_ptr),
    .g0  (g0),
    .g1  (g1)
  );

  // Gating with reset keeps ready low while the block is held in reset.
  assign req0_ready = g0 & reset;
  assign req1_ready = g1 & reset;
  assign fire0      = req0_valid & req0_ready;
  assign fire1      = req1_valid & req1_ready;
  assign xfer       = fire0 | fire1;
  assign contend    = req0_valid & req1_valid;
  assign sel_rd     = fire1 ? req1_rd   : req0_rd;
  assign sel_data   = fire1 ? req1_data : req0_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regwrite   <= 1'b0;
      write_reg  <= REG_X0;
      write_data <= '0;
      rr_ptr     <= 1'b0;
      stall_cnt  <= '0;
    end else begin
      regwrite <= xfer && (sel_rd != REG_X0);
      // x0 writes are consumed but leave the port contents untouched.
      if (xfer && (sel_rd != REG_X0)) begin
        write_reg  <= sel_rd;
        write_data <= sel_data;
      end
      if (xfer)
        rr_ptr <= fire0;
      if (contend && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench for regfile_wb_arbiter (CNT_W = 4 so saturation is reachable).
module tb_regfile_wb_arbiter;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } wr_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]       req0_rd = '0, req1_rd = '0;
  logic [XLEN-1:0]  req0_data = '0, req1_data = '0;
  logic             req0_ready, req1_ready;
  logic             regwrite;
  logic [4:0]       write_reg;
  logic [XLEN-1:0]  write_data;
  logic [CNT_W-1:0] stall_cnt;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t exp_q[$];

  regfile_wb_arbiter #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_rd    (req0_rd),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_rd    (req1_rd),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .regwrite   (regwrite),
    .write_reg  (write_reg),
    .write_data (write_data),
    .stall_cnt  (stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest expected write.
  always @(posedge clock) begin
    #1;
    if (regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write", write_reg, write_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_reg", 64'(write_reg), 64'(e.rd));
        chk("wb_data", 64'(write_data), 64'(e.data));
      end
    end
  end

  // One cycle of stimulus: drive at negedge, check hand-computed readies,
  // queue the write the accepted request should produce.
  task automatic cyc(input logic v0, input logic [4:0] rd0, input logic [XLEN-1:0] d0,
                     input logic v1, input logic [4:0] rd1, input logic [XLEN-1:0] d1,
                     input logic e0, input logic e1, input string nm);
    @(negedge clock);
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    #1;
    chk({nm, "_ready0"}, 64'(req0_ready), 64'(e0));
    chk({nm, "_ready1"}, 64'(req1_ready), 64'(e1));
    if (e0 && rd0 != 5'd0) exp_q.push_back('{rd0, d0});
    if (e1 && rd1 != 5'd0) exp_q.push_back('{rd1, d1});
  endtask

  task automatic idle();
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    // Reset state, with both requesters valid: readies must stay low.
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ready0", 64'(req0_ready), 64'd0);
    chk("rst_ready1", 64'(req1_ready), 64'd0);
    chk("rst_regwrite", 64'(regwrite), 64'd0);
    chk("rst_write_reg", 64'(write_reg), 64'd0);
    chk("rst_write_data", 64'(write_data), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b1;

    // Lone ALU request.
    cyc(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, 1, 0, "single");
    idle();
    #1;
    chk("single_regwrite", 64'(regwrite), 64'd1);
    chk("single_write_reg", 64'(write_reg), 64'd5);
    chk("single_write_data", 64'(write_data), 64'hDEADBEEF);
    chk("single_stall", 64'(stall_cnt), 64'd0);

    // Contention after reset: 0,1,0,1.
    do_reset();
    cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, "rr0");
    cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, "rr1");
    cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 1, 0, "rr2");
    cyc(1, 5'd1, 32'h11, 1, 5'd2, 32'h22, 0, 1, "rr3");
    idle();
    #1;
    chk("rr_stall", 64'(stall_cnt), 64'd4);

    // Idle gaps keep the pointer; the last loser (req0) wins next.
    idle();
    idle();
    #1;
    chk("idle_regwrite", 64'(regwrite), 64'd0);
    chk("idle_write_reg_hold", 64'(write_reg), 64'd2);
    cyc(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 1, 0, "gap0");
    idle();
    idle();
    cyc(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 0, 1, "gap1");
    idle();
    #1;
    chk("gap_stall", 64'(stall_cnt), 64'd6);

    // Write to x0 is consumed but not performed.
    cyc(0, 5'd0, 32'h0, 1, 5'd0, 32'h55, 0, 1, "x0");
    idle();
    #1;
    chk("x0_regwrite", 64'(regwrite), 64'd0);
    chk("x0_write_reg", 64'(write_reg), 64'd4);
    chk("x0_write_data", 64'(write_data), 64'h44);

    // Drive the stall counter to 14, then into saturation.
    for (int i = 0; i < 8; i++)
      cyc(1, 5'd8, 32'h80 + i, 1, 5'd9, 32'h90 + i, (i % 2) == 0, (i % 2) == 1, "sat_pre");
    idle();
    #1;
    chk("stall_14", 64'(stall_cnt), 64'd14);
    for (int i = 8; i < 11; i++)
      cyc(1, 5'd8, 32'h80 + i, 1, 5'd9, 32'h90 + i, (i % 2) == 0, (i % 2) == 1, "sat");
    idle();
    #1;
    chk("stall_sat", 64'(stall_cnt), 64'd15);
    idle();
    #1;
    chk("stall_hold", 64'(stall_cnt), 64'd15);

    // Reset right after a transfer to x7; pointer returns to req0.
    cyc(1, 5'd7, 32'h77, 0, 5'd0, 32'h0, 1, 0, "pre_rst");
    @(negedge clock);
    req0_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_regwrite", 64'(regwrite), 64'd0);
    chk("midrst_write_reg", 64'(write_reg), 64'd0);
    chk("midrst_stall", 64'(stall_cnt), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    idle();
    #1;
    chk("post_rst_regwrite", 64'(regwrite), 64'd0);
    cyc(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 1, 0, "post_rst");
    idle();
    idle();

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data width of write-back data.
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-005 req0_valid  in  1; req0_rd  in  5; req0_data  in  XLEN: ALU write-back request.
REQ-006 req0_ready  out  1: ALU request accepted this cycle.
REQ-007 req1_valid  in  1; req1_rd  in  5; req1_data  in  XLEN: LSU write-back request.
REQ-008 req1_ready  out  1: LSU request accepted this cycle.
REQ-009 regwrite  out  1; write_reg  out  5; write_data  out  XLEN: registered register-file write port.
REQ-010 stall_cnt  out  CNT_W: saturating count of cycles in which a valid requester was refused.

Function
REQ-011 The block SHALL accept at most one request per cycle; a request transfers when valid and ready are both 1 at a posedge.
REQ-012 ready SHALL be combinational from the valid inputs and the round-robin pointer, with no combinational path from rd/data.
REQ-013 Single valid requester: its ready SHALL be 1 and the other ready SHALL be 0.
REQ-014 Both valid: the requester selected by rr_ptr (0 = req0, 1 = req1) SHALL get ready = 1 and the other ready = 0.
REQ-015 After each accepted transfer, rr_ptr SHALL point to the requester that did not win, so each requester waits at most one cycle under contention.
REQ-016 rr_ptr SHALL NOT change in cycles with no transfer.
REQ-017 Accepted request with rd != 0: next cycle regwrite = 1, write_reg = rd, write_data = data (latency 1).
REQ-018 Accepted request with rd == 0: the request SHALL still be consumed (ready = 1), but next cycle regwrite SHALL be 0; x0 is never written.
REQ-019 No accepted request: next cycle regwrite SHALL be 0, and write_reg/write_data SHALL hold their previous values.
REQ-020 A requester SHALL hold valid, rd and data stable until accepted; the block does not check this.
REQ-021 stall_cnt SHALL increment by 1 in each cycle where exactly one valid requester is refused.
REQ-022 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-023 With reset deasserted, the output register SHALL always load (no back-pressure from the register file).

Reset
REQ-024 While reset = 0, the block SHALL asynchronously clear: regwrite = 0, write_reg = 0, write_data = 0, rr_ptr = 0, stall_cnt = 0.
REQ-025 While reset = 0, req0_ready and req1_ready SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL drop the in-flight write; regwrite SHALL be 0 on the first cycle after release.
REQ-027 After reset, the first contention SHALL be granted to req0.

Structure
REQ-028 The register-address width (5) and the x0 index constant SHALL live in the shared core package, together with XLEN.
REQ-029 The round-robin grant logic SHALL be one sub-module, rr_arb2 (inputs: two valids and a pointer; outputs: two grants), reusable elsewhere in the core.
REQ-030 The register-file instance is outside this block; this block drives only its write port.

Verification
REQ-031 Only req0 valid (rd=5, data=0xDEADBEEF) -> req0_ready=1; next cycle regwrite=1, write_reg=5, write_data=0xDEADBEEF; stall_cnt=0.
REQ-032 Both valid for 4 cycles after reset (req0 rd=1, req1 rd=2) -> grants alternate 0,1,0,1; write_reg sequence 1,2,1,2; stall_cnt=4.
REQ-033 req1 valid with rd=0, data=0x55 -> req1_ready=1; next cycle regwrite=0 and write_reg/write_data unchanged.
REQ-034 Preload stall_cnt to all-ones-1 via contention (CNT_W overridden to 4), then 3 more contention cycles -> stall_cnt=15 and held.
REQ-035 Assert reset on the cycle after a transfer to rd=7 -> regwrite=0, write_reg=0 immediately; after release, first contention grants req0.
REQ-036 Idle cycles between transfers -> regwrite=0, rr_ptr unchanged; the next contention grants the requester that lost last.
